vga_fill_ctrl: RTL
==================

Name: vga_fill_ctrl

Overview:
- Rectangle-fill sequencer sitting between the CPU/Avalon interconnect and vga_avalon.
- Software configures two corners and a colour through an Avalon-MM slave port, then writes start.
- The block then issues one Avalon-MM master write per pixel to vga_avalon, in row-major order.
- Frees the CPU from per-pixel writes and serialises all fill traffic to the VGA slave.

Parameters:
- SCREEN_W, 160, visible width; x valid when x < SCREEN_W.
- SCREEN_H, 120, visible height; y valid when y < SCREEN_H.
- COORD_W, 8, width of each x/y coordinate field.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- s_address  input  3  slave register index.
- s_read  input  1  slave read strobe.
- s_write  input  1  slave write strobe.
- s_writedata  input  32  slave write data.
- s_readdata  output  32  slave read data, registered, read latency 1.
- m_address  output  4  master address to vga_avalon; constant 0.
- m_write  output  1  master write request.
- m_writedata  output  32  {y[31:24], x[23:16], 8'h00, colour[7:0]}.
- m_waitrequest  input  1  vga_avalon stall.
- irq  output  1  level interrupt: done AND irq_en.

Behaviour:
- Registers, selected by s_address:
  - 0 CORNER0 RW: {y0[31:24], x0[23:16]}.
  - 1 CORNER1 RW: {y1[31:24], x1[23:16]}.
  - 2 COLOUR RW: [7:0].
  - 3 CTRL:
    - write: bit0 start (self-clearing), bit1 irq_en.
    - read: bit0 busy, bit1 irq_en, bit2 done.
  - 4 STATUS: read [15:0] = count of pixels accepted in the last or current fill. Any write clears done.
  - Unused addresses read 0; writes to them are ignored.
- Reset: every register, the counter, done and irq_en go to 0. Outputs reset to m_write=0, m_writedata=0, s_readdata=0, irq=0, state=IDLE.
- While busy, writes to CORNER0, CORNER1, COLOUR and CTRL.start are ignored. CTRL.irq_en stays writable. A write to STATUS clears done in any state.
- FSM:
  - IDLE: on an s_write to CTRL with bit0=1, clear done and the pixel count, then go to LOAD.
  - LOAD: one cycle. xs=min(x0,x1), xe=max(x0,x1), ys=min(y0,y1), ye=max(y0,y1). Cursor set to (xs,ys). Go to ISSUE.
  - ISSUE: m_write=1 with the cursor and colour on m_writedata.
    - A write is accepted when m_write && !m_waitrequest. On acceptance, count increments.
    - Cursor advance: if x==xe then x=xs and y=y+1, else x=x+1.
    - Acceptance of the pixel (xe,ye) goes to DONE.
    - m_writedata and m_write are held stable while m_waitrequest=1.
  - DONE: one cycle. m_write=0, done=1, then go to IDLE.
- Latency: start write at edge N gives LOAD in cycle N+1 and the first m_write in cycle N+2. With m_waitrequest=0 the block issues one pixel per cycle.
- Total writes = (xe-xs+1)*(ye-ys+1). Count is 16 bits; the maximum 256*256 wraps to 0, which is documented and acceptable.
- Degenerate case x0==x1 and y0==y1: exactly one write.
- busy = state is not IDLE.
- Simultaneous done-set (DONE state) and STATUS write: done-set wins.
- Reset asserted mid-fill: m_write drops at that edge. No further writes are issued and the state returns to IDLE.
- s_read with s_write in the same cycle: the write takes effect, and readdata shows the pre-write value.

Optional Feature:
- Macro: VGA_FILL_CLIP_EN.
- Defined: in LOAD, xe=min(xe,SCREEN_W-1) and ye=min(ye,SCREEN_H-1). If xs>=SCREEN_W or ys>=SCREEN_H, go straight to DONE with count=0 and no m_write. No out-of-range writes reach vga_avalon.
- Undefined: no clipping. All pixels are issued and vga_avalon drops the out-of-bound ones. Count includes the dropped pixels.

Test Plan:
- Reset, then read CTRL and STATUS -> 0. m_write=0, irq=0.
- CORNER0={y=10,x=20}, CORNER1={y=11,x=22}, COLOUR=8'h7F, start, no waitrequest -> 6 writes: 0x0A14007F, 0x0A15007F, 0x0A16007F, 0x0B14007F, 0x0B15007F, 0x0B16007F. Then STATUS=6 and CTRL.done=1.
- Swapped corners CORNER0={y=5,x=9}, CORNER1={y=4,x=8}, COLOUR=3 -> the first write is 0x04080003 and there are 4 writes total.
- Hold m_waitrequest=1 for 3 cycles on the second pixel -> m_writedata is stable throughout, with no skipped or duplicated pixel.
- With irq_en=1, a fill ends -> irq=1. A STATUS write -> irq=0. Writing CORNER0 while busy -> register unchanged.
- With VGA_FILL_CLIP_EN, corners (x=158,y=118)/(x=165,y=125) -> 4 writes, max x=159, max y=119. With x0=x1=170 -> 0 writes and done=1. Without the macro, the first case gives 64 writes.

Source files
------------

// File: rtl/vga_fill_ctrl_if.sv
// Bus bundle for vga_fill_ctrl: CPU-facing Avalon-MM slave port plus irq, and
// the Avalon-MM master port toward vga_avalon.
interface vga_fill_ctrl_if;
    logic [2:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        irq;

    logic [3:0]  m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    modport slave (
        input  s_address, s_read, s_write, s_writedata,
        output s_readdata, irq
    );

    modport master (
        output m_address, m_write, m_writedata,
        input  m_waitrequest
    );
endinterface

// File: rtl/vga_fill_ctrl.sv
// Rectangle-fill sequencer: programmed over an Avalon-MM slave, emits one
// master write per pixel in row-major order. Optional macro VGA_FILL_CLIP_EN clips to the screen.
module vga_fill_ctrl #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int COORD_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    vga_fill_ctrl_if.slave   s_bus,
    vga_fill_ctrl_if.master  m_bus
);

`ifdef VGA_FILL_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    localparam logic [COORD_W:0]   W_LIM = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0]   H_LIM = (COORD_W+1)'(SCREEN_H);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_t;

    state_t r_state, w_state_next;

    logic [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;
    logic [7:0]         r_colour;
    logic               r_irq_en;
    logic               r_done;
    logic [15:0]        r_count;
    logic [COORD_W-1:0] r_xs, r_xe, r_ye;
    logic [COORD_W-1:0] r_cx, r_cy;
    logic [31:0]        r_readdata;

    logic               w_busy;
    logic               w_wr_ctrl;
    logic               w_wr_status;
    logic               w_start;
    logic               w_accept;
    logic               w_last;
    logic               w_offscreen;
    logic [COORD_W-1:0] w_xs, w_xe, w_ys, w_ye;
    logic [31:0]        w_rd_mux;

    assign w_busy      = (r_state != IDLE);
    assign w_wr_ctrl   = s_bus.s_write && (s_bus.s_address == 3'd3);
    assign w_wr_status = s_bus.s_write && (s_bus.s_address == 3'd4);
    assign w_start     = w_wr_ctrl && s_bus.s_writedata[0] && (r_state == IDLE);
    assign w_accept    = (r_state == ISSUE) && !m_bus.m_waitrequest;
    assign w_last      = (r_cx == r_xe) && (r_cy == r_ye);

    // Normalise corners; with clipping, trim the far edge and flag a fill
    // whose near corner already lies off screen.
    always_comb begin
        w_xs        = (r_x0 < r_x1) ? r_x0 : r_x1;
        w_xe        = (r_x0 < r_x1) ? r_x1 : r_x0;
        w_ys        = (r_y0 < r_y1) ? r_y0 : r_y1;
        w_ye        = (r_y0 < r_y1) ? r_y1 : r_y0;
        w_offscreen = 1'b0;
        if (CLIP) begin
            if (w_xe > X_MAX) w_xe = X_MAX;
            if (w_ye > Y_MAX) w_ye = Y_MAX;
            w_offscreen = ({1'b0, w_xs} >= W_LIM) || ({1'b0, w_ys} >= H_LIM);
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_state_next = LOAD;
            LOAD:    w_state_next = w_offscreen ? DONE : ISSUE;
            ISSUE:   if (w_accept && w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_rd_mux = 32'h0;
        unique case (s_bus.s_address)
            3'd0:    w_rd_mux = {8'(r_y0), 8'(r_x0), 16'h0};
            3'd1:    w_rd_mux = {8'(r_y1), 8'(r_x1), 16'h0};
            3'd2:    w_rd_mux = {24'h0, r_colour};
            3'd3:    w_rd_mux = {29'h0, r_done, r_irq_en, w_busy};
            3'd4:    w_rd_mux = {16'h0, r_count};
            default: w_rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x0       <= '0;
            r_y0       <= '0;
            r_x1       <= '0;
            r_y1       <= '0;
            r_colour   <= '0;
            r_irq_en   <= 1'b0;
            r_done     <= 1'b0;
            r_count    <= '0;
            r_xs       <= '0;
            r_xe       <= '0;
            r_ye       <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_readdata <= '0;
        end else begin
            // Read mux sees pre-write register values on a combined read/write.
            r_readdata <= s_bus.s_read ? w_rd_mux : 32'h0;

            if (s_bus.s_write && !w_busy) begin
                unique case (s_bus.s_address)
                    3'd0: begin
                        r_x0 <= s_bus.s_writedata[16 +: COORD_W];
                        r_y0 <= s_bus.s_writedata[24 +: COORD_W];
                    end
                    3'd1: begin
                        r_x1 <= s_bus.s_writedata[16 +: COORD_W];
                        r_y1 <= s_bus.s_writedata[24 +: COORD_W];
                    end
                    3'd2:    r_colour <= s_bus.s_writedata[7:0];
                    default: ;
                endcase
            end

            if (w_wr_ctrl) r_irq_en <= s_bus.s_writedata[1];

            if (r_state == DONE)              r_done <= 1'b1;
            else if (w_start || w_wr_status)  r_done <= 1'b0;

            if (w_start)       r_count <= '0;
            else if (w_accept) r_count <= r_count + 16'd1;

            if (r_state == LOAD) begin
                r_xs <= w_xs;
                r_xe <= w_xe;
                r_ye <= w_ye;
                r_cx <= w_xs;
                r_cy <= w_ys;
            end else if (w_accept) begin
                if (r_cx == r_xe) begin
                    r_cx <= r_xs;
                    r_cy <= r_cy + 1'b1;
                end else begin
                    r_cx <= r_cx + 1'b1;
                end
            end
        end
    end

    assign m_bus.m_address   = 4'h0;
    assign m_bus.m_write     = (r_state == ISSUE);
    assign m_bus.m_writedata = (r_state == ISSUE) ? {8'(r_cy), 8'(r_cx), 8'h00, r_colour} : 32'h0;
    assign s_bus.s_readdata  = r_readdata;
    assign s_bus.irq         = r_done & r_irq_en;

endmodule
